// File: rtl/masked_rand_dispenser.sv
// Sequences a 128-bit LFSR PRNG, buffers its words and serialises them LSB-first into OUT_W-bit mask chunks.
// FIFO head reaches rnd_o with zero latency; consumer backpressure holds the chunk, and a full FIFO or exhausted period stalls the PRNG.
module masked_rand_dispenser #(
    parameter int PRNG_W        = 128,
    parameter int OUT_W         = 32,
    parameter int DEPTH         = 4,
    parameter int RESEED_PERIOD = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_valid_i,
    input  logic [PRNG_W-1:0] seed_i,
    output logic              seed_ready_o,
    output logic              prng_init_o,
    output logic              prng_en_o,
    output logic [PRNG_W-1:0] prng_seed_o,
    input  logic [PRNG_W-1:0] prng_i,
    output logic              rnd_valid_o,
    input  logic              rnd_ready_i,
    output logic [OUT_W-1:0]  rnd_o,
    output logic              reseed_req_o,
    output logic              seeded_o
);

    localparam int NCHUNK = PRNG_W / OUT_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(RESEED_PERIOD + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] PERIOD   = CNT_W'(RESEED_PERIOD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        DISCARD = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t            r_state;
    logic [PRNG_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_word_cnt;
    logic [PRNG_W-1:0] r_seed;
    logic              r_seeded;
    logic              r_reseed;

    logic              w_seed_hs;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_take;
    logic              w_pop;
    logic [PRNG_W-1:0] w_head;

    assign seed_ready_o = (r_state == IDLE) || (r_state == RUN);
    assign w_seed_hs    = seed_valid_i && seed_ready_o;

    // Full comes from the registered count only, so a same-cycle pop never frees a slot for a push.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = (r_state == RUN) && !w_full && (r_word_cnt < PERIOD);
    assign w_take  = !w_empty && rnd_ready_i;
    assign w_pop   = w_take && (r_idx == LAST_IDX);

    // DISCARD steps the PRNG past the raw seed without pushing it.
    assign prng_init_o  = (r_state == LOAD);
    assign prng_en_o    = w_push || (r_state == DISCARD);
    assign prng_seed_o  = r_seed;
    assign reseed_req_o = r_reseed;
    assign seeded_o     = r_seeded;

    assign w_head      = r_mem[r_rd_ptr];
    assign rnd_valid_o = !w_empty;
    assign rnd_o       = w_empty ? '0 : w_head[r_idx*OUT_W +: OUT_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_seed     <= '0;
            r_seeded   <= 1'b0;
            r_reseed   <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            case (r_state)
                IDLE:    if (w_seed_hs) r_state <= LOAD;
                LOAD:    r_state <= DISCARD;
                DISCARD: r_state <= RUN;
                RUN:     if (w_seed_hs) r_state <= LOAD;
                default: r_state <= IDLE;
            endcase

            if (w_seed_hs) begin
                r_seed   <= seed_i;
                r_seeded <= 1'b1;
            end

            // A reseed handshake wins over a push landing in the same cycle.
            if (w_seed_hs) begin
                r_word_cnt <= '0;
            end else if (w_push) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end

            if (w_seed_hs) begin
                r_reseed <= 1'b0;
            end else if (r_word_cnt == PERIOD) begin
                r_reseed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_idx    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_take) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= prng_i;
        end
    end

endmodule
